// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions used by the OAM DMA sequencer.
package ppu_pkg;

    // Bytes copied per OAM DMA transfer (0x00..0x9F)
    localparam int unsigned OAM_LEN = 160;

    // Register select of the DMA register (FF46) inside the PPU register block
    localparam logic [4:0] DMA_REG_SEL = 5'h6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2
    } oamdma_state_t;

endpackage

// File: rtl/oamdma_controller.sv
// OAM DMA sequencer: copies OAM_LEN bytes from {src, 8'h00} into OAM,
// one byte per M-cycle, owning the system bus while the copy runs.
module oamdma_controller
    import ppu_pkg::*;
#(
    parameter int unsigned OAM_LEN      = ppu_pkg::OAM_LEN,
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        start,
    input  logic [7:0]  start_addr,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active,
    output logic [15:0] bus_addr,
    output logic        bus_read,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_busy,
    output logic        done
);

    oamdma_state_t state, state_nxt;
    logic [7:0]    src_reg, src_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [7:0]    setup_cnt, cnt_nxt;
    logic          restarted, restarted_nxt;
    logic          done_nxt;
    logic          start_ok;
    logic          last_byte;

    // Sources in the E0..FF page are never legal DMA sources
    assign start_ok  = start && cpu_en && (start_addr[7:5] != 3'b111);
    assign last_byte = (idx == 8'(OAM_LEN - 1));

    // State, source, index and setup counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src_reg   <= '0;
            idx       <= '0;
            setup_cnt <= '0;
            restarted <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            src_reg   <= src_nxt;
            idx       <= idx_nxt;
            setup_cnt <= cnt_nxt;
            restarted <= restarted_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state logic and per-cycle bus/OAM strobes
    always_comb begin
        state_nxt     = state;
        src_nxt       = src_reg;
        idx_nxt       = idx;
        cnt_nxt       = setup_cnt;
        restarted_nxt = restarted;
        done_nxt      = 1'b0;
        dma_active    = 1'b0;
        bus_read      = 1'b0;
        oam_we        = 1'b0;
        oam_addr      = '0;
        oam_wdata     = '0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    src_nxt       = start_addr;
                    cnt_nxt       = 8'(SETUP_CYCLES);
                    idx_nxt       = '0;
                    restarted_nxt = 1'b0;
                    state_nxt     = SETUP;
                end
            end

            SETUP: begin
                // Initial setup leaves the bus to the CPU; a restart keeps it
                dma_active = restarted;
                if (start_ok) begin
                    src_nxt       = start_addr;
                    cnt_nxt       = 8'(SETUP_CYCLES);
                    idx_nxt       = '0;
                    restarted_nxt = 1'b1;
                end else if (cpu_en) begin
                    if (setup_cnt <= 8'd1) begin
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        state_nxt = XFER;
                    end else begin
                        cnt_nxt = setup_cnt - 8'd1;
                    end
                end
            end

            XFER: begin
                dma_active = 1'b1;
                bus_read   = 1'b1;
                // A restart wins over the byte write of the same tick
                if (start_ok) begin
                    src_nxt       = start_addr;
                    cnt_nxt       = 8'(SETUP_CYCLES);
                    idx_nxt       = '0;
                    restarted_nxt = 1'b1;
                    state_nxt     = SETUP;
                end else if (cpu_en) begin
                    oam_we    = 1'b1;
                    oam_addr  = idx;
                    oam_wdata = bus_rdata;
                    if (last_byte) begin
                        idx_nxt       = '0;
                        done_nxt      = 1'b1;
                        restarted_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign oam_busy = dma_active;
    assign bus_addr = dma_active ? {src_reg, idx} : '0;

endmodule
